// File: rtl/midi_message_assembler_pkg.sv
// Shared MIDI constants, FSM state type and status-length helper
// for the MIDI message assembler.
package midi_pkg;

   localparam logic [7:0] MIDI_NOTE_OFF    = 8'h80;
   localparam logic [7:0] MIDI_NOTE_ON     = 8'h90;
   localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
   localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;
   localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_D1,
      WAIT_D2,
      SYSEX
   } midi_state_e;

   // Program change and channel pressure carry one data byte.
   function automatic logic [1:0] midi_data_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd2;
      if (status[7:4] == 4'hC || status[7:4] == 4'hD) len = 2'd1;
      return len;
   endfunction

endpackage

// File: rtl/midi_message_assembler_if.sv
// Byte-stream in / assembled-message out bundle of the MIDI assembler.
// master: UART side and message consumer; slave: the assembler.
interface midi_message_assembler_if;

   logic       rx_byte_valid;
   logic [7:0] rx_byte;
   logic       midi_byte_ready;
   logic [7:0] midi_byte0;
   logic [7:0] midi_byte1;
   logic [7:0] midi_byte2;

   modport master (
      output rx_byte_valid, rx_byte,
      input  midi_byte_ready, midi_byte0, midi_byte1, midi_byte2
   );

   modport slave (
      input  rx_byte_valid, rx_byte,
      output midi_byte_ready, midi_byte0, midi_byte1, midi_byte2
   );

endinterface

// File: rtl/midi_message_assembler.sv
// Assembles MIDI channel-voice messages with running status, SysEx skip
// and real-time passthrough. Optional feature: MIDI_CHANNEL_FILTER_EN.
module midi_message_assembler
   import midi_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic                          clk,
   input  logic                          reset,
   midi_message_assembler_if.slave       bus
);

   midi_state_e state_q, state_d;
   logic [7:0]  run_status_q, run_status_d;
   logic [7:0]  d1_q, d1_d;
   logic        ready_q, ready_d;
   logic [7:0]  byte0_q, byte0_d;
   logic [7:0]  byte1_q, byte1_d;
   logic [7:0]  byte2_q, byte2_d;

   logic        emit;
   logic [7:0]  emit_d1;
   logic [7:0]  emit_d2;
   logic        chan_ok;

`ifdef MIDI_CHANNEL_FILTER_EN
   assign chan_ok = (run_status_q[3:0] == CHANNEL);
`else
   logic unused_channel;
   assign unused_channel = ^CHANNEL;
   assign chan_ok        = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      run_status_d = run_status_q;
      d1_d         = d1_q;
      ready_d      = 1'b0;
      byte0_d      = byte0_q;
      byte1_d      = byte1_q;
      byte2_d      = byte2_q;
      emit         = 1'b0;
      emit_d1      = 8'h00;
      emit_d2      = 8'h00;

      if (bus.rx_byte_valid) begin
         if (!bus.rx_byte[7]) begin
            unique case (state_q)
               IDLE, WAIT_D1: begin
                  if (run_status_q != 8'h00) begin
                     d1_d = bus.rx_byte;
                     if (midi_data_len(run_status_q) == 2'd2) begin
                        state_d = WAIT_D2;
                     end else begin
                        emit    = 1'b1;
                        emit_d1 = bus.rx_byte;
                        state_d = IDLE;
                     end
                  end
               end
               WAIT_D2: begin
                  emit    = 1'b1;
                  emit_d1 = d1_q;
                  emit_d2 = bus.rx_byte;
                  state_d = IDLE;
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end else if (bus.rx_byte < MIDI_SYSEX_START) begin
            run_status_d = bus.rx_byte;
            state_d      = WAIT_D1;
         end else if (bus.rx_byte == MIDI_SYSEX_START) begin
            run_status_d = 8'h00;
            state_d      = SYSEX;
         end else if (bus.rx_byte < MIDI_RT_MIN) begin
            // F1..F7, including SysEx end, cancel running status.
            run_status_d = 8'h00;
            state_d      = IDLE;
         end
      end

      if (emit && chan_ok) begin
         ready_d = 1'b1;
         byte0_d = run_status_q;
         byte1_d = emit_d1;
         byte2_d = emit_d2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         run_status_q <= 8'h00;
         d1_q         <= 8'h00;
         ready_q      <= 1'b0;
         byte0_q      <= 8'h00;
         byte1_q      <= 8'h00;
         byte2_q      <= 8'h00;
      end else begin
         state_q      <= state_d;
         run_status_q <= run_status_d;
         d1_q         <= d1_d;
         ready_q      <= ready_d;
         byte0_q      <= byte0_d;
         byte1_q      <= byte1_d;
         byte2_q      <= byte2_d;
      end
   end

   assign bus.midi_byte_ready = ready_q;
   assign bus.midi_byte0      = byte0_q;
   assign bus.midi_byte1      = byte1_q;
   assign bus.midi_byte2      = byte2_q;

endmodule

// File: tb/tb_midi_message_assembler.sv
// Directed-vector bench for midi_message_assembler; CHANNEL is 1 so the
// filtered build (MIDI_CHANNEL_FILTER_EN) can be exercised as well.
module tb_midi_message_assembler;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   strobes;

   midi_message_assembler_if bus ();

   midi_message_assembler #(
      .CHANNEL (4'd1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.midi_byte_ready) strobes++;
   end

   task automatic send(input logic [7:0] b);
      bus.rx_byte_valid = 1'b1;
      bus.rx_byte       = b;
      @(posedge clk);
      #1;
      bus.rx_byte_valid = 1'b0;
      bus.rx_byte       = 8'hAA;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_msg(input string nm, input logic [7:0] e0,
                          input logic [7:0] e1, input logic [7:0] e2);
      checks++;
      if (bus.midi_byte_ready !== 1'b1 || bus.midi_byte0 !== e0 ||
          bus.midi_byte1 !== e1 || bus.midi_byte2 !== e2) begin
         errors++;
         $display("FAIL %s got rdy=%b %h/%h/%h want rdy=1 %h/%h/%h", nm,
                  bus.midi_byte_ready, bus.midi_byte0, bus.midi_byte1,
                  bus.midi_byte2, e0, e1, e2);
      end
   endtask

   task automatic chk_cnt(input string nm, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_cycles(2);
      reset = 1'b0;
      checks++;
      if (bus.midi_byte_ready !== 1'b0 || bus.midi_byte0 !== 8'h00 ||
          bus.midi_byte1 !== 8'h00 || bus.midi_byte2 !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b %h/%h/%h want 0 00/00/00",
                  bus.midi_byte_ready, bus.midi_byte0, bus.midi_byte1,
                  bus.midi_byte2);
      end
      idle_cycles(1);
   endtask

   task automatic test_running_status();
      int s0;
      s0 = strobes;
      send(8'h90);
      send(8'h3C);
      send(8'h64);
      chk_msg("note_on", 8'h90, 8'h3C, 8'h64);
      send(8'h3E);
      send(8'h50);
      chk_msg("running_status", 8'h90, 8'h3E, 8'h50);
      idle_cycles(1);
      chk_cnt("running_strobes", strobes - s0, 2);
   endtask

   task automatic test_one_data_byte();
      send(8'hC2);
      send(8'h05);
      chk_msg("prog_change", 8'hC2, 8'h05, 8'h00);
      send(8'h07);
      chk_msg("prog_change_rs", 8'hC2, 8'h07, 8'h00);
      idle_cycles(1);
   endtask

   task automatic test_realtime();
      int s0;
      s0 = strobes;
      send(8'h90);
      send(8'h3C);
      send(8'hF8);
      send(8'h64);
      chk_msg("realtime_mid", 8'h90, 8'h3C, 8'h64);
      idle_cycles(1);
      chk_cnt("realtime_strobes", strobes - s0, 1);
   endtask

   task automatic test_sysex();
      int s0;
      s0 = strobes;
      send(8'hF0);
      send(8'h7E);
      send(8'h01);
      send(8'h90);
      send(8'h3C);
      send(8'h40);
      chk_msg("after_sysex", 8'h90, 8'h3C, 8'h40);
      idle_cycles(1);
      chk_cnt("sysex_strobes", strobes - s0, 1);
      s0 = strobes;
      send(8'hF0);
      send(8'h01);
      send(8'h02);
      send(8'hF7);
      send(8'h3C);
      send(8'h40);
      idle_cycles(1);
      chk_cnt("sysex_clears_rs", strobes - s0, 0);
      checks++;
      if (bus.midi_byte0 !== 8'h90 || bus.midi_byte1 !== 8'h3C ||
          bus.midi_byte2 !== 8'h40) begin
         errors++;
         $display("FAIL outputs_hold got %h/%h/%h want 90/3C/40",
                  bus.midi_byte0, bus.midi_byte1, bus.midi_byte2);
      end
   endtask

   task automatic test_reset_mid_message();
      int s0;
      s0 = strobes;
      send(8'h90);
      send(8'h3C);
      reset = 1'b1;
      idle_cycles(1);
      reset = 1'b0;
      send(8'h64);
      idle_cycles(2);
      chk_cnt("reset_mid_msg", strobes - s0, 0);
   endtask

   task automatic test_back_to_back();
      int s0;
      send(8'h80);
      send(8'h3C);
      send(8'h00);
      chk_msg("latency_1cyc", 8'h80, 8'h3C, 8'h00);
      idle_cycles(1);
      checks++;
      if (bus.midi_byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL strobe_width got %b want 0", bus.midi_byte_ready);
      end
      s0 = strobes;
      send(8'hD3);
      send(8'h11);
      chk_msg("b2b_first", 8'hD3, 8'h11, 8'h00);
      send(8'h22);
      chk_msg("b2b_second", 8'hD3, 8'h22, 8'h00);
      idle_cycles(1);
      chk_cnt("b2b_strobes", strobes - s0, 2);
   endtask

   task automatic test_channel_filter();
      int s0;
      s0 = strobes;
      send(8'h90);
      send(8'h3C);
      send(8'h64);
      idle_cycles(1);
      chk_cnt("filter_drop_ch0", strobes - s0, 0);
      checks++;
      if (bus.midi_byte0 !== 8'h00) begin
         errors++;
         $display("FAIL filter_no_update got %h want 00", bus.midi_byte0);
      end
      send(8'h91);
      send(8'h3C);
      send(8'h64);
      chk_msg("filter_pass_ch1", 8'h91, 8'h3C, 8'h64);
      send(8'h3D);
      send(8'h65);
      chk_msg("filter_pass_rs", 8'h91, 8'h3D, 8'h65);
      idle_cycles(1);
      chk_cnt("filter_strobes", strobes - s0, 2);
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      strobes           = 0;
      reset             = 1'b1;
      bus.rx_byte_valid = 1'b0;
      bus.rx_byte       = 8'h00;
      @(posedge clk);
      #1;
      test_reset();
`ifdef MIDI_CHANNEL_FILTER_EN
      test_channel_filter();
`else
      test_running_status();
      test_one_data_byte();
      test_realtime();
      test_sysex();
      test_reset_mid_message();
      test_back_to_back();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
